seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Iterative signed divider, the inverse of the combinational 16x16 multiplier: 32-bit dividend / 16-bit divisor
//  -> 16-bit quotient + 16-bit remainder. Sits beside the multiplier in the ALU datapath.
//  Restoring algorithm, one quotient bit per clock, valid/ready handshake on both sides.
// PARAMETERS
//  WIDTH  16  divisor/quotient/remainder width; dividend is 2*WIDTH. CNT_W = $clog2(2*WIDTH).
// PORTS
//  clk         in   1        single clock, all state on rising edge
//  rst_n       in   1        synchronous, active-low reset
//  in_valid    in   1        dividend/divisor valid
//  in_ready    out  1        high only in IDLE
//  dividend    in   2*WIDTH  two's-complement dividend
//  divisor     in   WIDTH    two's-complement divisor
//  out_valid   out  1        result valid; held until out_ready
//  out_ready   in   1        consumer accepts result
//  quotient    out  WIDTH    two's-complement quotient, truncated toward zero
//  remainder   out  WIDTH    two's-complement remainder, sign of dividend
//  div_zero    out  1        divisor was 0
//  overflow    out  1        true quotient does not fit WIDTH bits signed
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, in_ready=1, out_valid=0, quotient=remainder=0, flags=0. Overrides
//   everything, including mid-CALC; partial result discarded, no out_valid.
//  FSM: IDLE -> (in_valid & divisor!=0) -> CALC; IDLE -> (in_valid & divisor==0) -> DONE;
//   CALC -> (step count==2*WIDTH-1) -> FIX; FIX -> DONE; DONE -> (out_ready) -> IDLE.
//  Accept edge: latch |dividend|, |divisor|, sign_q = sign(dividend)^sign(divisor), sign_r = sign(dividend);
//   clear partial remainder (WIDTH+1 bits) and step count.
//  CALC: per edge shift {rem,dvd} left 1; trial = rem - |divisor|; if trial >= 0 keep it, set quotient bit 1;
//   else restore, bit 0. Exactly 2*WIDTH steps; quotient magnitude is 2*WIDTH bits.
//  FIX: overflow = (mag > 2^(WIDTH-1)-1 when sign_q=0) or (mag > 2^(WIDTH-1) when sign_q=1).
//   quotient = low WIDTH bits of signed result (truncated even on overflow); remainder = sign_r ? -rem : rem.
//  Latency: out_valid rises 2*WIDTH+2 cycles after the accept edge (34 for WIDTH=16); fixed, data-independent.
//  Divide by zero: no CALC; out_valid one cycle after accept, div_zero=1, quotient=0,
//   remainder=dividend[WIDTH-1:0], overflow=0.
//  Outputs registered; stable while out_valid=1 and out_ready=0 (back-pressure unlimited).
//  DONE with out_ready=1: out_valid drops next cycle; in_ready rises that same next cycle (no same-cycle
//   re-accept). in_valid outside IDLE is ignored. Results/flags hold until next FIX/DONE load.
//  |-2^(2*WIDTH-1)| handled as unsigned 2^(2*WIDTH-1) magnitude (no wrap), divisor likewise.
// STRUCTURE
//  alu_pkg: div_state_t enum {IDLE, CALC, FIX, DONE}; localparams DIV_WIDTH=16, DIV_CNT_W.
//  Sub-module div_step (combinational): one shift/trial-subtract/restore step, ports rem_in, dvd_msb, dsr,
//   rem_out, q_bit. seq_divider holds FSM, counter, registers, sign fix-up.
// TESTING
//  100 / 7 -> q=0x000E, r=0x0002, flags 0, out_valid exactly 34 cycles after accept.
//  -100 (0xFFFFFF9C) / 7 -> q=0xFFF2, r=0xFFFE; 100 / -7 (0xFFF9) -> q=0xFFF2, r=0x0002.
//  1234 / 0 -> div_zero=1, q=0x0000, r=0x04D2, out_valid 1 cycle after accept.
//  0x00008000 / 1 -> overflow=1, q=0x8000; 0xFFFF8000 / 1 -> overflow=0, q=0x8000, r=0.
//  Hold out_ready=0 for 10 cycles -> out_valid, q, r stable; in_valid pulses ignored; then accept -> IDLE.
//  rst_n=0 at step 10 of CALC -> next cycle IDLE, in_ready=1, out_valid=0, outputs 0; new op completes correctly.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared types and sizing for the iterative signed divider.
package seq_divider_pkg;
  localparam int DIV_WIDTH = 16;
  localparam int DIV_CNT_W = $clog2(2*DIV_WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;
endpackage

// File: rtl/seq_divider_if.sv
// Request/response handshake bundle between the ALU datapath and the divider.
interface seq_divider_if #(parameter int WIDTH = 16);
  logic                 in_valid;
  logic                 in_ready;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 div_zero;
  logic                 overflow;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero, overflow
  );
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero, overflow
  );
endinterface

// File: rtl/seq_divider_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(parameter int WIDTH = 16) (
  input  logic [WIDTH:0]   i_rem_in,
  input  logic             i_dvd_msb,
  input  logic [WIDTH-1:0] i_dsr,
  output logic [WIDTH:0]   o_rem_out,
  output logic             o_q_bit
);
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH:0]   w_trial;

  assign w_shift = {i_rem_in, i_dvd_msb};
  // Partial remainder stays below the divisor, so the difference fits WIDTH+1 bits when kept.
  assign w_trial   = w_shift[WIDTH:0] - {1'b0, i_dsr};
  assign o_q_bit   = (w_shift >= {2'b00, i_dsr});
  assign o_rem_out = o_q_bit ? w_trial : w_shift[WIDTH:0];
endmodule

// File: rtl/seq_divider.sv
// Signed 2W/W restoring divider, one quotient bit per clock, valid/ready on both sides.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  seq_divider_if.slave  bus
);
  localparam int                DW      = 2*WIDTH;
  localparam int                CNT_W   = $clog2(DW);
  localparam logic [CNT_W-1:0]  LAST    = CNT_W'(DW-1);
  localparam logic [DW-1:0]     POS_MAX = DW'(2**(WIDTH-1)-1);

  div_state_t        r_state, w_next;
  logic [WIDTH:0]    r_rem;
  logic [DW-1:0]     r_dvd;
  logic [WIDTH-1:0]  r_dsr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_sign_q, r_sign_r;
  logic [WIDTH-1:0]  r_quot, r_remd;
  logic              r_dz, r_ov;

  logic              w_dsr_zero;
  logic [DW-1:0]     w_dvd_abs;
  logic [WIDTH-1:0]  w_dsr_abs;
  logic [WIDTH:0]    w_rem_nxt;
  logic              w_q_bit;
  logic [WIDTH-1:0]  w_quot_fix, w_rem_fix;
  logic              w_ov_fix;

  assign w_dsr_zero = (bus.divisor == '0);
  // Magnitudes kept unsigned so the most-negative values do not wrap.
  assign w_dvd_abs  = bus.dividend[DW-1]  ? (~bus.dividend + DW'(1))   : bus.dividend;
  assign w_dsr_abs  = bus.divisor[WIDTH-1] ? (~bus.divisor + WIDTH'(1)) : bus.divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem_in  (r_rem),
    .i_dvd_msb (r_dvd[DW-1]),
    .i_dsr     (r_dsr),
    .o_rem_out (w_rem_nxt),
    .o_q_bit   (w_q_bit)
  );

  // After the last step r_dvd holds the full quotient magnitude.
  assign w_quot_fix = r_sign_q ? (~r_dvd[WIDTH-1:0] + WIDTH'(1)) : r_dvd[WIDTH-1:0];
  assign w_rem_fix  = r_sign_r ? (~r_rem[WIDTH-1:0] + WIDTH'(1)) : r_rem[WIDTH-1:0];
  assign w_ov_fix   = r_dvd > (POS_MAX + DW'(r_sign_q));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid) w_next = w_dsr_zero ? DONE : CALC;
      CALC:    if (r_cnt == LAST) w_next = FIX;
      FIX:     w_next = DONE;
      DONE:    if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (r_state == IDLE);
    bus.out_valid = (r_state == DONE);
    bus.quotient  = r_quot;
    bus.remainder = r_remd;
    bus.div_zero  = r_dz;
    bus.overflow  = r_ov;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dsr    <= '0;
      r_cnt    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_quot   <= '0;
      r_remd   <= '0;
      r_dz     <= 1'b0;
      r_ov     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          if (w_dsr_zero) begin
            r_quot <= '0;
            r_remd <= bus.dividend[WIDTH-1:0];
            r_dz   <= 1'b1;
            r_ov   <= 1'b0;
          end else begin
            r_dvd    <= w_dvd_abs;
            r_dsr    <= w_dsr_abs;
            r_sign_q <= bus.dividend[DW-1] ^ bus.divisor[WIDTH-1];
            r_sign_r <= bus.dividend[DW-1];
            r_rem    <= '0;
            r_cnt    <= '0;
          end
        end
        CALC: begin
          r_rem <= w_rem_nxt;
          r_dvd <= {r_dvd[DW-2:0], w_q_bit};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        FIX: begin
          r_quot <= w_quot_fix;
          r_remd <= w_rem_fix;
          r_dz   <= 1'b0;
          r_ov   <= w_ov_fix;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: arithmetic reference model plus literal vectors.
module tb_seq_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [15:0] exp_q, exp_r;
  logic        exp_dz, exp_ov;

  seq_divider_if #(.WIDTH(16)) dif();

  seq_divider #(.WIDTH(16)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (dif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference: plain signed arithmetic, truncating division, remainder takes dividend sign.
  task automatic model(input logic [31:0] a, input logic [15:0] b,
                       output logic [15:0] q, output logic [15:0] r,
                       output logic dz, output logic ov);
    longint sa, sb, lq, lr;
    sa = $signed(a);
    sb = $signed(b);
    if (sb == 0) begin
      q = '0; r = a[15:0]; dz = 1'b1; ov = 1'b0;
    end else begin
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[15:0];
      r  = lr[15:0];
      dz = 1'b0;
      ov = (lq > 32767) || (lq < -32768);
    end
  endtask

  // Every cycle a result is presented it must match the model for the accepted operation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && dif.out_valid === 1'b1) begin
      chk("mon_q",  32'(dif.quotient),  32'(exp_q));
      chk("mon_r",  32'(dif.remainder), 32'(exp_r));
      chk("mon_dz", 32'(dif.div_zero),  32'(exp_dz));
      chk("mon_ov", 32'(dif.overflow),  32'(exp_ov));
    end
  end

  task automatic chk_idle_zero(input string nm);
    chk({nm, "_in_ready"},  32'(dif.in_ready),  32'd1);
    chk({nm, "_out_valid"}, 32'(dif.out_valid), 32'd0);
    chk({nm, "_q"},         32'(dif.quotient),  32'd0);
    chk({nm, "_r"},         32'(dif.remainder), 32'd0);
    chk({nm, "_flags"},     {30'd0, dif.div_zero, dif.overflow}, 32'd0);
  endtask

  task automatic run_op(input string nm, input logic [31:0] a, input logic [15:0] b,
                        input int lat, input logic [15:0] ql, input logic [15:0] rl,
                        input logic dzl, input logic ovl, input int hold);
    logic [15:0] mq, mr, sq, sr;
    logic        mdz, mov;
    int          n;
    model(a, b, mq, mr, mdz, mov);
    chk({nm, "_model_q"}, 32'(mq), 32'(ql));
    chk({nm, "_model_r"}, 32'(mr), 32'(rl));
    chk({nm, "_model_f"}, {30'd0, mdz, mov}, {30'd0, dzl, ovl});
    @(negedge clk);
    exp_q = mq; exp_r = mr; exp_dz = mdz; exp_ov = mov;
    dif.dividend = a; dif.divisor = b; dif.in_valid = 1'b1; dif.out_ready = 1'b0;
    n = 0;
    while (dif.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      chk({nm, "_accept_timeout"}, 32'(n), 32'd0);
      dif.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 dif.in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dif.out_valid !== 1'b1 && n < 100);
    chk({nm, "_latency"}, 32'(n), 32'(lat));
    if (dif.out_valid !== 1'b1) return;
    chk({nm, "_lit_q"}, 32'(dif.quotient),  32'(ql));
    chk({nm, "_lit_r"}, 32'(dif.remainder), 32'(rl));
    chk({nm, "_lit_f"}, {30'd0, dif.div_zero, dif.overflow}, {30'd0, dzl, ovl});
    sq = dif.quotient;
    sr = dif.remainder;
    for (int i = 0; i < hold; i++) begin
      dif.in_valid = (i % 2 == 0);
      dif.dividend = 32'h1234_5678;
      dif.divisor  = 16'h0003;
      @(negedge clk);
      chk({nm, "_hold_valid"}, 32'(dif.out_valid), 32'd1);
      chk({nm, "_hold_ready"}, 32'(dif.in_ready),  32'd0);
      chk({nm, "_hold_q"},     32'(dif.quotient),  32'(sq));
      chk({nm, "_hold_r"},     32'(dif.remainder), 32'(sr));
    end
    dif.in_valid  = 1'b0;
    dif.out_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_drop_valid"}, 32'(dif.out_valid), 32'd0);
    chk({nm, "_idle_ready"}, 32'(dif.in_ready),  32'd1);
    dif.out_ready = 1'b0;
  endtask

  initial begin
    dif.in_valid = 1'b0; dif.dividend = '0; dif.divisor = '0; dif.out_ready = 1'b0;
    exp_q = '0; exp_r = '0; exp_dz = 1'b0; exp_ov = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_zero("reset");
    rst_n = 1'b1;

    run_op("p100_7",  32'd100,       16'd7,      34, 16'h000E, 16'h0002, 1'b0, 1'b0, 0);
    run_op("n100_7",  32'hFFFFFF9C,  16'd7,      34, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 0);
    run_op("p100_n7", 32'd100,       16'hFFF9,   34, 16'hFFF2, 16'h0002, 1'b0, 1'b0, 0);
    run_op("divzero", 32'd1234,      16'd0,       1, 16'h0000, 16'h04D2, 1'b1, 1'b0, 0);
    run_op("ovf_pos", 32'h00008000,  16'd1,      34, 16'h8000, 16'h0000, 1'b0, 1'b1, 0);
    run_op("min_neg", 32'hFFFF8000,  16'd1,      34, 16'h8000, 16'h0000, 1'b0, 1'b0, 10);

    // Abort mid-CALC: reset must discard the partial result and clear registered outputs.
    @(negedge clk);
    dif.dividend = 32'd5000; dif.divisor = 16'd3; dif.in_valid = 1'b1;
    @(posedge clk);
    #1 dif.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("calc_busy_ready", 32'(dif.in_ready),  32'd0);
    chk("calc_busy_valid", 32'(dif.out_valid), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk_idle_zero("midreset");
    rst_n = 1'b1;

    run_op("big_ovf", 32'h7FFFFFFF,  16'h7FFF,   34, 16'h0002, 16'h0001, 1'b0, 1'b1, 0);
    run_op("min_m1",  32'h80000000,  16'hFFFF,   34, 16'h0000, 16'h0000, 1'b0, 1'b1, 0);
    run_op("dsr_min", 32'h000186A0,  16'h8000,   34, 16'hFFFD, 16'h06A0, 1'b0, 1'b0, 0);
    run_op("n7_2",    32'hFFFFFFF9,  16'd2,      34, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 3);
    run_op("small",   32'd7,         16'hFF9C,   34, 16'h0000, 16'h0007, 1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
